decoder_upsample_concat: RTL and testbench

- First stage of each decoder level. Consumes a low-resolution feature map (for example, the encoder's stage3_output) as a word stream.
- Performs 2x nearest-neighbour upsampling and interleaves each upsampled pixel's channels with the matching skip-connection channels (skip3/skip2/skip1).
- Emits the concatenated high-resolution map to the following decoder conv stage.
- Word order everywhere is row, then column, then channel: idx = (r*W*C)+(c*C)+ch. Data is 16-bit Q8.8 signed.

---
 rtl/decoder_pkg.sv | 25 ++
 rtl/decoder_row_buffer.sv | 28 ++
 rtl/decoder_upsample_concat.sv | 203 ++++++++++++++++++++
 tb/tb_decoder_upsample_concat.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types, widths and sizing helpers for the decoder upsample/concat stage
package decoder_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT_UP,
    EMIT_SKIP,
    DONE
  } state_e;

  // One buffered low-res row: every channel of every pixel in the row.
  function automatic int buf_depth(input int w, input int c_up);
    return w * c_up;
  endfunction

  // Bits needed to hold a counter whose largest value is max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/decoder_row_buffer.sv
// rtl/decoder_row_buffer.sv - one low-res row of words, synchronous write and asynchronous read
module decoder_row_buffer
  import decoder_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Contents are never cleared; every location is written before it is read in a row.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: one word per accepted low-res input.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/decoder_upsample_concat.sv
// rtl/decoder_upsample_concat.sv - 2x nearest upsample of a low-res map interleaved with skip channels
// Build option: define DECODER_UP_RELU_EN to force negative upsampled words to zero.
module decoder_upsample_concat
  import decoder_pkg::*;
#(
  parameter int IN_WIDTH      = 8,
  parameter int IN_HEIGHT     = 8,
  parameter int UP_CHANNELS   = 4,
  parameter int SKIP_CHANNELS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] up_data,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] skip_data,
  input  logic              skip_valid,
  output logic              skip_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int BUF_DEPTH = buf_depth(IN_WIDTH, UP_CHANNELS);
  localparam int ADDR_W    = cnt_w(BUF_DEPTH - 1);
  localparam int OX_W      = cnt_w(2 * IN_WIDTH - 1);
  localparam int ROW_W     = cnt_w(IN_HEIGHT - 1);
  localparam int CH_MAX    = (UP_CHANNELS > SKIP_CHANNELS) ? UP_CHANNELS - 1 : SKIP_CHANNELS - 1;
  localparam int CH_W      = cnt_w(CH_MAX);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BUF_DEPTH - 1);
  localparam logic [OX_W-1:0]   OX_LAST   = OX_W'(2 * IN_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IN_HEIGHT - 1);
  localparam logic [CH_W-1:0]   CHU_LAST  = CH_W'(UP_CHANNELS - 1);
  localparam logic [CH_W-1:0]   CHS_LAST  = CH_W'(SKIP_CHANNELS - 1);

  state_e            state_q;
  logic [ROW_W-1:0]  row_q;
  logic              sub_q;
  logic [OX_W-1:0]   ox_q;
  logic [CH_W-1:0]   ch_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              done_q;
  logic              up_ready_q;

  logic              buf_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] up_word;
  logic              up_xfer;
  logic              skip_xfer;
  logic              frame_end;

  assign up_xfer   = up_ready_q && up_valid;
  assign skip_xfer = (state_q == EMIT_SKIP) && skip_valid && out_ready;
  assign buf_we    = up_xfer;

  // Each high-res column pair maps back onto the same low-res pixel.
  assign rd_addr   = ADDR_W'((int'(ox_q) >> 1) * UP_CHANNELS + int'(ch_q));

  // Final high-res pixel of the frame: last low-res row, replay pass, last column.
  assign frame_end = (row_q == ROW_LAST) && sub_q && (ox_q == OX_LAST);

  decoder_row_buffer #(
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_row_buffer (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (addr_q),
    .wdata_i (up_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

`ifdef DECODER_UP_RELU_EN
  assign up_word = rd_data[DATA_W-1] ? '0 : rd_data;
`else
  assign up_word = rd_data;
`endif

  // Frame sequencer: load a row, then emit it twice with skip channels after each pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      sub_q      <= 1'b0;
      ox_q       <= '0;
      ch_q       <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      up_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            row_q      <= '0;
            sub_q      <= 1'b0;
            ox_q       <= '0;
            ch_q       <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b1;
            up_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (up_xfer) begin
            if (addr_q == ADDR_LAST) begin
              addr_q     <= '0;
              ch_q       <= '0;
              up_ready_q <= 1'b0;
              state_q    <= EMIT_UP;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        EMIT_UP: begin
          if (out_ready) begin
            if (ch_q == CHU_LAST) begin
              ch_q    <= '0;
              state_q <= EMIT_SKIP;
            end else begin
              ch_q <= ch_q + CH_W'(1);
            end
          end
        end
        EMIT_SKIP: begin
          if (skip_xfer) begin
            if (ch_q == CHS_LAST) begin
              ch_q <= '0;
              if (ox_q != OX_LAST) begin
                ox_q    <= ox_q + OX_W'(1);
                state_q <= EMIT_UP;
              end else if (!sub_q) begin
                sub_q   <= 1'b1;
                ox_q    <= '0;
                state_q <= EMIT_UP;
              end else if (row_q != ROW_LAST) begin
                row_q      <= row_q + ROW_W'(1);
                sub_q      <= 1'b0;
                ox_q       <= '0;
                up_ready_q <= 1'b1;
                state_q    <= LOAD;
              end else begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end else begin
              ch_q <= ch_q + CH_W'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          up_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Output steering: buffered up words, or skip words passed straight through.
  always_comb begin
    out_data   = '0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    skip_ready = 1'b0;
    case (state_q)
      EMIT_UP: begin
        out_valid = 1'b1;
        out_data  = up_word;
      end
      EMIT_SKIP: begin
        out_valid  = skip_valid;
        out_data   = skip_data;
        skip_ready = out_ready;
        out_last   = frame_end && (ch_q == CHS_LAST);
      end
      default: begin
        out_data = '0;
      end
    endcase
  end

  assign up_ready = up_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_decoder_upsample_concat.sv
// tb/tb_decoder_upsample_concat.sv - directed self-checking bench for decoder_upsample_concat
module tb_decoder_upsample_concat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] up_data;
  logic        up_valid;
  logic [15:0] skip_data;
  logic        skip_valid;
  logic        out_ready;
  logic        sel;

  logic start_s, start_d;
  assign start_s = start & ~sel;
  assign start_d = start & sel;

  logic        s_up_ready, s_skip_ready, s_out_valid, s_out_last, s_busy, s_done;
  logic [15:0] s_out_data;
  logic        d_up_ready, d_skip_ready, d_out_valid, d_out_last, d_busy, d_done;
  logic [15:0] d_out_data;

  logic        up_ready, skip_ready, out_valid, out_last, busy, done;
  logic [15:0] out_data;
  assign up_ready   = sel ? d_up_ready   : s_up_ready;
  assign skip_ready = sel ? d_skip_ready : s_skip_ready;
  assign out_valid  = sel ? d_out_valid  : s_out_valid;
  assign out_last   = sel ? d_out_last   : s_out_last;
  assign busy       = sel ? d_busy       : s_busy;
  assign done       = sel ? d_done       : s_done;
  assign out_data   = sel ? d_out_data   : s_out_data;

  decoder_upsample_concat #(
    .IN_WIDTH(2), .IN_HEIGHT(2), .UP_CHANNELS(1), .SKIP_CHANNELS(1)
  ) u_small (
    .clk(clk), .rst(rst), .start(start_s),
    .up_data(up_data), .up_valid(up_valid), .up_ready(s_up_ready),
    .skip_data(skip_data), .skip_valid(skip_valid), .skip_ready(s_skip_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_last(s_out_last), .busy(s_busy), .done(s_done)
  );

  decoder_upsample_concat #(
    .IN_WIDTH(8), .IN_HEIGHT(8), .UP_CHANNELS(4), .SKIP_CHANNELS(4)
  ) u_dflt (
    .clk(clk), .rst(rst), .start(start_d),
    .up_data(up_data), .up_valid(up_valid), .up_ready(d_up_ready),
    .skip_data(skip_data), .skip_valid(skip_valid), .skip_ready(d_skip_ready),
    .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_last(d_out_last), .busy(d_busy), .done(d_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Hand-computed output of the 2x2, 1+1 channel frame.
  logic [15:0] small_tbl [32] = '{
    16'h0100, 16'h0A00, 16'h0100, 16'h0A01, 16'h0101, 16'h0A02, 16'h0101, 16'h0A03,
    16'h0100, 16'h0A04, 16'h0100, 16'h0A05, 16'h0101, 16'h0A06, 16'h0101, 16'h0A07,
    16'h0102, 16'h0A08, 16'h0102, 16'h0A09, 16'h0103, 16'h0A0A, 16'h0103, 16'h0A0B,
    16'h0102, 16'h0A0C, 16'h0102, 16'h0A0D, 16'h0103, 16'h0A0E, 16'h0103, 16'h0A0F
  };

`ifdef DECODER_UP_RELU_EN
  localparam logic [15:0] RELU_UP_EXP = 16'h0000;
`else
  localparam logic [15:0] RELU_UP_EXP = 16'hFF00;
`endif

  logic [15:0] exp_q [$];
  int  fw, fh, fcu, fcs;
  bit  relu_mode = 1'b0;

  function automatic logic [15:0] up_src(input int i);
    if (relu_mode && i == 0) return 16'hFF00;
    return 16'(32'h0100 + i);
  endfunction

  function automatic logic [15:0] skip_src(input int i);
    if (relu_mode && i == 0) return 16'hFF00;
    return 16'(32'h0A00 + i);
  endfunction

  task automatic build_small(input bit relu);
    exp_q.delete();
    fw = 2; fh = 2; fcu = 1; fcs = 1;
    for (int i = 0; i < 32; i++) begin
      if (relu && small_tbl[i] == 16'h0100)      exp_q.push_back(RELU_UP_EXP);
      else if (relu && small_tbl[i] == 16'h0A00) exp_q.push_back(16'hFF00);
      else                                       exp_q.push_back(small_tbl[i]);
    end
  endtask

  task automatic build_dflt();
    int n;
    exp_q.delete();
    fw = 8; fh = 8; fcu = 4; fcs = 4;
    n = 0;
    for (int r = 0; r < 2 * fh; r++)
      for (int x = 0; x < 2 * fw; x++) begin
        for (int ch = 0; ch < fcu; ch++)
          exp_q.push_back(16'(32'h0100 + ((r / 2) * fw + (x / 2)) * fcu + ch));
        for (int ch = 0; ch < fcs; ch++) begin
          exp_q.push_back(16'(32'h0A00 + n));
          n++;
        end
      end
  endtask

  // mode 0: free flow, 1: out_ready toggles, 2: skip starvation at first skip slot
  task automatic run_frame(input int mode, input int abort_at, input string nm);
    int oi, ui, si, cyc, ndone, starve, total;
    bit fin, stall, starving;
    logic [15:0] stall_data;
    logic        stall_last;
    oi = 0; ui = 0; si = 0; cyc = 0; ndone = 0; starve = 0;
    fin = 1'b0; stall = 1'b0;
    total = exp_q.size();
    @(negedge clk);
    start = 1'b1; up_valid = 1'b0; skip_valid = 1'b0; out_ready = 1'b1;
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      up_valid   = 1'b1;
      up_data    = up_src(ui);
      skip_data  = skip_src(si);
      skip_valid = 1'b1;
      out_ready  = (mode == 1) ? 1'(cyc % 2) : 1'b1;
      start      = (mode == 1 && oi == 5);
      starving   = (mode == 2 && oi == fcu && starve < 10);
      if (starving) begin
        skip_valid = 1'b0;
        out_ready  = 1'(starve % 2);
        starve++;
      end
      #1;
      if (done) ndone++;
      if (starving) begin
        check({nm, "_starve_valid"}, out_valid, 1'b0);
        check({nm, "_starve_ready"}, skip_ready, out_ready);
      end
      if (stall) begin
        check({nm, "_stall_valid"}, out_valid, 1'b1);
        check({nm, "_stall_data"}, out_data, stall_data);
        check({nm, "_stall_last"}, out_last, stall_last);
      end
      stall      = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
      if (oi == total) begin
        check({nm, "_done_pulse"}, done, 1'b1);
        fin = 1'b1;
      end else begin
        if (up_valid && up_ready) ui++;
        if (skip_valid && skip_ready) si++;
        if (out_valid && out_ready) begin
          check({nm, "_data"}, out_data, exp_q[oi]);
          check({nm, "_last"}, out_last, (oi == total - 1));
          oi++;
        end
        if (abort_at >= 0 && oi >= abort_at) fin = 1'b1;
      end
    end
    check({nm, "_finished"}, fin, 1'b1);
    up_valid = 1'b0; skip_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    if (abort_at < 0) begin
      @(negedge clk);
      #1;
      check({nm, "_done_clear"}, done, 1'b0);
      check({nm, "_idle"}, busy, 1'b0);
      check({nm, "_done_count"}, ndone, 1);
      check({nm, "_up_count"}, ui, fw * fh * fcu);
      check({nm, "_skip_count"}, si, 4 * fw * fh * fcs);
      check({nm, "_out_count"}, oi, total);
    end
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; start = 1'b1;
    up_valid = 1'b1; skip_valid = 1'b1; out_ready = 1'b1;
    up_data = 16'h1234; skip_data = 16'h5678;
    repeat (5) @(negedge clk);
    #1;
    check("rst_small_outs", {s_up_ready, s_skip_ready, s_out_valid, s_out_last, s_busy, s_done, s_out_data}, '0);
    check("rst_dflt_outs",  {d_up_ready, d_skip_ready, d_out_valid, d_out_last, d_busy, d_done, d_out_data}, '0);
    start = 1'b0; up_valid = 1'b0; skip_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle_small_busy", s_busy, 1'b0);
    check("idle_dflt_busy", d_busy, 1'b0);

    build_small(1'b0);
    run_frame(0, -1, "basic");
    run_frame(1, -1, "bp");
    run_frame(2, -1, "starve");

    relu_mode = 1'b1;
    build_small(1'b1);
    run_frame(0, -1, "relu");
    relu_mode = 1'b0;

    sel = 1'b1;
    build_dflt();
    run_frame(0, 300, "abort");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_up_ready", up_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    run_frame(0, -1, "full");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
